// File: rtl/core_ctrl.sv
// Multi-cycle FETCH/EXEC/WB sequencer for the RV32 datapath: owns pc, ir,
// the instruction-fetch handshake, next-pc selection, write enables and halt/fault.
module core_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] ir,
   input  logic [31:0] rs1_data,
   input  logic [31:0] imm,
   input  logic        br_taken,
   output logic        rf_wen,
   output logic [4:0]  rf_waddr,
   output logic        halted,
   output logic        err,
   output logic [31:0] instret
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_WB    = 3'd3;
   localparam logic [2:0] S_HALT  = 3'd4;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [31:0] EBREAK    = 32'h0010_0073;
   localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

   logic [2:0]  state;
   logic [7:0]  wait_cnt;
   logic [31:0] next_pc_q;
   logic        misalign_q;
   logic        wb_wen_q;

   logic [6:0]  opcode;
   logic        is_wb_class;
   logic        is_branch;
   logic        is_ebreak;
   logic [31:0] next_pc;
   logic [31:0] seq_pc;

   // Instruction classification and next-pc selection, valid while ir is held in EXEC.
   always_comb begin
      opcode      = ir[6:0];
      is_ebreak   = (ir == EBREAK);
      is_branch   = (opcode == OP_BRANCH);
      is_wb_class = 1'b0;
      seq_pc      = pc + 32'd4;
      next_pc     = seq_pc;
      case (opcode)
         OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: is_wb_class = 1'b1;
         default:                                            is_wb_class = 1'b0;
      endcase
      case (opcode)
         OP_JAL:    next_pc = pc + imm;
         OP_JALR:   next_pc = (rs1_data + imm) & ~32'd1;
         OP_BRANCH: next_pc = br_taken ? (pc + imm) : seq_pc;
         default:   next_pc = seq_pc;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         pc         <= RESET_PC;
         ir         <= '0;
         instret    <= '0;
         wait_cnt   <= '0;
         err        <= 1'b0;
         next_pc_q  <= '0;
         misalign_q <= 1'b0;
         wb_wen_q   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // branch below sees the pre-edge values of pc, ir and wait_cnt.
         case (state)
            S_IDLE: begin
               wait_cnt <= '0;
               state    <= S_FETCH;
            end
            S_FETCH: begin
               if (imem_ready) begin
                  ir    <= imem_rdata;
                  state <= S_EXEC;
               end else if (wait_cnt == WAIT_LAST) begin
                  err   <= 1'b1;
                  state <= S_HALT;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_EXEC: begin
               if (is_ebreak) begin
                  state <= S_HALT;
               end else if (!(is_wb_class || is_branch)) begin
                  err   <= 1'b1;
                  state <= S_HALT;
               end else begin
                  // NOTE: EXEC results are registered so WB outputs depend on
                  // state only, never combinationally on datapath inputs.
                  next_pc_q  <= next_pc;
                  misalign_q <= |next_pc[1:0];
                  wb_wen_q   <= is_wb_class && (ir[11:7] != 5'd0) && (next_pc[1:0] == 2'b00);
                  state      <= S_WB;
               end
            end
            S_WB: begin
               if (misalign_q) begin
                  err   <= 1'b1;
                  state <= S_HALT;
               end else begin
                  pc       <= next_pc_q;
                  instret  <= instret + 32'd1;
                  wait_cnt <= '0;
                  state    <= S_FETCH;
               end
            end
            S_HALT: state <= S_HALT;
            default: begin
               err   <= 1'b1;
               state <= S_HALT;
            end
         endcase
      end
   end

   // Async reset returns state to IDLE, which drops rf_wen without waiting for a clock.
   assign imem_req  = (state == S_FETCH);
   assign imem_addr = pc;
   assign rf_wen    = (state == S_WB) && wb_wen_q;
   assign rf_waddr  = ir[11:7];
   assign halted    = (state == S_HALT);

endmodule

// File: doc/core_ctrl.md
# core_ctrl

Multi-cycle sequencer for the RV32 datapath (register file, ALU, immediate decode). It replaces the free-running PC and instruction register and the `wen = clk` write strobe with an explicit FETCH/EXEC/WB state machine. It owns the PC, the instruction register, a fetch handshake to instruction memory, next-PC selection, one-cycle register-file write enables, halt/error detection and a retired-instruction counter.

## Interface
- RESET_PC, 32'h80000000, PC value loaded on reset
- TIMEOUT, 255, consecutive not-ready FETCH cycles before fetch fault (1..255)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= pc)
- imem_ready  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- pc  out  32  current PC, to datapath (AUIPC/JAL link)
- ir  out  32  latched instruction, to decoder
- rs1_data  in  32  register-file read port 1
- imm  in  32  decoded immediate
- br_taken  in  1  ALU branch condition for current ir
- rf_wen  out  1  register-file write enable
- rf_waddr  out  5  = ir[11:7]
- halted  out  1  sticky halt
- err  out  1  sticky fault (valid when halted)
- instret  out  32  retired instruction count

## Operation
- States: IDLE, FETCH, EXEC, WB, HALT. Reset state IDLE.
- IDLE -> FETCH unconditionally on the first clock after rst deasserts.
- FETCH: imem_req=1, imem_addr=pc. If imem_ready=1: ir<=imem_rdata and go to EXEC. Otherwise stay, increment wait_cnt.
- EXEC: classify ir[6:0]:
  - writeback: OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, LOAD-free core, so no LOAD/STORE.
  - BRANCH 1100011: no writeback.
  - ir == 32'h00100073 (ebreak): go to HALT with err=0.
  - Any other encoding: go to HALT with err=1.
  - Legal classes go to WB.
- next_pc:
  - JAL: pc+imm
  - JALR: (rs1_data+imm) & ~1
  - BRANCH: pc+imm if br_taken, else pc+4
  - all other classes: pc+4
  - All arithmetic is mod 2^32.
- WB:
  - If next_pc[1:0] != 0: go to HALT with err=1; pc and instret unchanged; rf_wen=0.
  - Otherwise: rf_wen=1 iff the class writes back and rd != 0. pc<=next_pc, instret<=instret+1 (wraps at 2^32), go to FETCH.
- HALT: absorbing until reset; imem_req=0, rf_wen=0; pc, ir and instret frozen.
- Fetch timeout:
  - wait_cnt clears on entering FETCH.
  - If imem_ready=0 while wait_cnt==TIMEOUT-1: go to HALT with err=1.
  - If imem_ready=1 on that same cycle, the fetch succeeds (ready wins).

## Timing
- Reset (rst low, immediate): state IDLE, pc=RESET_PC, ir=0, imem_req=0, rf_wen=0, halted=0, err=0, instret=0, wait_cnt=0.
- imem_req and rf_wen are decoded from registered state only; no input-to-output combinational path. imem_addr is pc.
- Handshake:
  - imem_req stays high with imem_addr stable until ready is seen.
  - imem_ready is ignored when imem_req=0.
  - imem_rdata is sampled on the edge where imem_req=imem_ready=1.
- Latency: 3 cycles per instruction with zero-wait memory (FETCH, EXEC, WB); each wait cycle adds 1.
- rf_wen is high for exactly the one WB cycle. The register file writes on that clock edge, and pc updates on the same edge.
- halted rises on the edge leaving EXEC/WB/FETCH for HALT, together with err.
- rst asserted mid-instruction: immediate return to reset values. Any pending write is dropped, and rf_wen is forced to 0 asynchronously.

## Test plan
- Reset, zero-wait memory returning addi x1,x0,5 (32'h00500093) at 80000000: imem_req high 1 cycle after reset release; rf_wen=1, rf_waddr=1 on 3rd cycle; pc=80000004, instret=1.
- imem_ready held low 3 cycles, then high: imem_addr stable throughout, ir captured on ready edge, instret increments once, no timeout.
- TIMEOUT=4, ready never asserted: halted=1, err=1 after exactly 4 FETCH cycles; pc=80000000, imem_req=0 thereafter.
- beq with br_taken=1, imm=-8 at pc 80000010: pc becomes 80000008 and rf_wen stays 0. jalr with rs1_data=80000101, imm=0: pc becomes 80000100 (bit 0 cleared). jal with imm=6: halted=1, err=1, pc unchanged.
- ebreak (00100073): halted=1, err=0; 32'hFFFFFFFF: halted=1, err=1; addi to x0: rf_wen=0, instret increments.
- rst pulsed low during the WB cycle: rf_wen drops immediately, pc=80000000, instret=0; fetch restarts 1 cycle after release.
